// File: rtl/public_key_gen.sv
// Sequential Pearson-hash key issuer: hashes an 8-bit private key over a 256-entry
// table and emits the tagged public key {KEY_TAG, hash8}.
module public_key_gen #(
   parameter int unsigned ROUNDS  = 8,
   parameter logic [3:0]  KEY_TAG = 4'b0010
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    private_key,
   input  logic [2047:0] random_table,
   output logic [11:0]   public_key,
   output logic          busy,
   output logic          done,
   output logic          key_valid
);

   typedef enum logic [0:0] {StIdle, StHash} state_t;

   state_t      state_q, state_d;
   logic [7:0]  key_q, key_d;
   logic [7:0]  h_q, h_d;
   logic [7:0]  r_q, r_d;
   logic [11:0] pk_q, pk_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        valid_q, valid_d;

   logic [7:0]  tbl_idx;
   logic [7:0]  tbl_val;
   logic [7:0]  last_round;

   // Table index for the current round; key + round wraps mod 256.
   assign tbl_idx    = h_q ^ (key_q + r_q);
   assign tbl_val    = random_table[{tbl_idx, 3'b000} +: 8];
   assign last_round = 8'(ROUNDS - 1);

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      h_d     = h_q;
      r_d     = r_q;
      pk_d    = pk_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_d   = private_key;
               h_d     = 8'h00;
               r_d     = 8'h00;
               busy_d  = 1'b1;
               state_d = StHash;
            end
         end
         StHash: begin
            h_d = tbl_val;
            r_d = r_q + 8'h01;
            if (r_q == last_round) begin
               pk_d    = {KEY_TAG, tbl_val};
               done_d  = 1'b1;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         key_q   <= 8'h00;
         h_q     <= 8'h00;
         r_q     <= 8'h00;
         pk_q    <= 12'h000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         h_q     <= h_d;
         r_q     <= r_d;
         pk_q    <= pk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
      end
   end

   assign public_key = pk_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign key_valid  = valid_q;

endmodule

// File: tb/tb_public_key_gen.sv
// Self-checking bench for public_key_gen: fixed-table vectors, corner sequences
// and random tables/keys against a Pearson-hash reference model.
module tb_public_key_gen;

   localparam int unsigned ROUNDS = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    private_key;
   logic [2047:0] random_table;
   logic [11:0]   public_key;
   logic          busy;
   logic          done;
   logic          key_valid;

   logic [7:0] tbl [256];
   int vectors = 0;
   int errors  = 0;

   public_key_gen #(.ROUNDS(ROUNDS), .KEY_TAG(4'b0010)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .private_key  (private_key),
      .random_table (random_table),
      .public_key   (public_key),
      .busy         (busy),
      .done         (done),
      .key_valid    (key_valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         mode;   // 0 identity table, 1 constant 0xA5 table
      logic [7:0] key;
      logic [11:0] exp_pk;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_table();
      for (int i = 0; i < 256; i++) random_table[8*i +: 8] = tbl[i];
   endtask

   task automatic set_mode(input int mode);
      for (int i = 0; i < 256; i++) tbl[i] = (mode == 0) ? 8'(i) : 8'hA5;
      load_table();
   endtask

   function automatic logic [7:0] model_hash(input logic [7:0] key);
      int h = 0;
      for (int r = 0; r < int'(ROUNDS); r++) h = int'(tbl[(h ^ ((int'(key) + r) % 256)) & 255]);
      return 8'(h);
   endfunction

   function automatic bit verifier_ok(input logic [7:0] key, input logic [11:0] pk);
      return (pk[11:8] == 4'b0010) && (pk[7:0] == model_hash(key));
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Starts one key from IDLE and checks the full cycle-by-cycle timeline.
   task automatic run_key(input logic [7:0] key, input logic [11:0] exp, input string name);
      start       = 1'b1;
      private_key = key;
      tick();
      start       = 1'b0;
      private_key = 8'($urandom);
      for (int c = 1; c <= int'(ROUNDS); c++) begin
         if (c < int'(ROUNDS)) begin
            if (busy !== 1'b1 || done !== 1'b0) check({name, " busy"}, {busy, done}, 2'b10);
            tick();
         end else begin
            tick();
            check({name, " done"}, {done, busy, key_valid}, 3'b101);
            check({name, " public_key"}, public_key, exp);
         end
      end
      tick();
      check({name, " done width"}, done, 1'b0);
   endtask

   initial begin
      vec_t vecs[3];
      int   done_cnt;
      int   t_first, t_second;
      logic [11:0] pk_first, pk_second;
      logic [7:0]  rkey;

      vecs[0] = '{0, 8'h03, 12'h208};
      vecs[1] = '{1, 8'h5A, 12'h2A5};
      vecs[2] = '{0, 8'h00, 12'h200};

      reset = 1'b1; start = 1'b0; private_key = 8'h00;
      set_mode(0);
      tick(); tick();
      check("reset outputs", {public_key, busy, done, key_valid}, {12'h000, 3'b000});
      start = 1'b1;
      tick();
      check("reset overrides start", busy, 1'b0);
      start = 1'b0;
      reset = 1'b0;
      tick();

      for (int v = 0; v < 3; v++) begin
         set_mode(vecs[v].mode);
         run_key(vecs[v].key, vecs[v].exp_pk, $sformatf("vec%0d", v));
      end

      // Start during busy is ignored: exactly one done pulse.
      set_mode(0);
      start = 1'b1; private_key = 8'h00;
      tick();
      start = 1'b0;
      done_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         start = (c == 3);
         private_key = 8'h03;
         tick();
         if (done) done_cnt++;
      end
      start = 1'b0;
      check("ignored start pulses", done_cnt, 1);
      check("ignored start pk", public_key, 12'h200);

      // Reset at E+4 aborts the operation.
      start = 1'b1; private_key = 8'h03;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) done_cnt++;
         tick();
      end
      check("abort no done", done_cnt, 0);
      check("abort state", {public_key, busy, key_valid}, {12'h000, 2'b00});
      run_key(8'h03, 12'h208, "after abort");

      // Back-to-back with start held high.
      start = 1'b1; private_key = 8'h03;
      tick();
      private_key = 8'h00;
      t_first = -1; t_second = -1;
      pk_first = 12'h000; pk_second = 12'h000;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (done && t_first < 0) begin
            t_first = c; pk_first = public_key;
         end else if (done && t_second < 0) begin
            t_second = c; pk_second = public_key; start = 1'b0;
         end
      end
      start = 1'b0;
      check("b2b first latency", t_first, int'(ROUNDS));
      check("b2b spacing", t_second - t_first, int'(ROUNDS) + 1);
      check("b2b pk first", pk_first, 12'h208);
      check("b2b pk second", pk_second, 12'h200);
      check("loopback 03 ok", verifier_ok(8'h03, pk_first), 1'b1);
      check("loopback 00 vs first", verifier_ok(8'h00, pk_first), 1'b0);
      check("loopback 00 ok", verifier_ok(8'h00, pk_second), 1'b1);
      check("loopback 03 vs second", verifier_ok(8'h03, pk_second), 1'b0);
      for (int c = 0; c < ROUNDS + 2; c++) tick();

      // Random tables and keys against the reference model.
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
         load_table();
         rkey = 8'($urandom);
         run_key(rkey, {4'b0010, model_hash(rkey)}, $sformatf("rand%0d", n));
         check($sformatf("rand%0d loopback", n), verifier_ok(rkey, public_key), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
